// File: rtl/sel_encoder.sv
// rtl/sel_encoder.sv - registered 8-to-3 request encoder with valid/ready output
// Collects request strobes into a pending set and issues one index per transfer.
module sel_encoder #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [2:0] S,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       dup
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [2:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic [7:0] pending_q, pending_d;
  logic       dup_q, dup_d;

  logic       load;
  logic [2:0] winner;
  logic [2:0] rr_off;
  logic [7:0] rotated;
  logic [7:0] grant_mask;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // Rotate so the pointer position lands at bit 0, then the lowest set bit is the RR offset.
  always_comb begin
    rotated = (pending_q >> ptr_q) | (pending_q << (4'd8 - {1'b0, ptr_q}));
    rr_off  = lowest_set(rotated);
    winner  = RR ? (ptr_q + rr_off) : lowest_set(pending_q);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ready) begin
          if (|pending_q) load = 1'b1;
          else            state_d = IDLE;
        end
      end
    endcase

    valid_d = (state_d == OFFER);

    if (load) begin
      s_d = winner;
      if (RR) ptr_d = winner + 3'd1;
    end

    // A same-edge request for the granted index survives the clear.
    grant_mask = load ? (8'b1 << winner) : 8'h00;
    pending_d  = (pending_q & ~grant_mask) | req;
    dup_d      = |(req & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s_q       <= 3'd0;
      ptr_q     <= 3'd0;
      valid_q   <= 1'b0;
      pending_q <= 8'h00;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      dup_q     <= dup_d;
    end
  end

  assign S       = s_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign dup     = dup_q;

endmodule

// File: tb/tb_sel_encoder.sv
// tb/tb_sel_encoder.sv - scoreboard bench for sel_encoder, round-robin and fixed-priority
module tb_sel_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;

  logic [2:0] s_rr, s_fp;
  logic       valid_rr, valid_fp;
  logic [7:0] pending_rr, pending_fp;
  logic       dup_rr, dup_fp;

  int n_vec  = 0;
  int n_fail = 0;
  int q_rr[$];
  int q_fp[$];

  always #5 clk = ~clk;

  sel_encoder #(.RR(1'b1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .req(req), .S(s_rr), .valid(valid_rr),
    .ready(ready), .pending(pending_rr), .dup(dup_rr)
  );

  sel_encoder #(.RR(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .req(req), .S(s_fp), .valid(valid_fp),
    .ready(ready), .pending(pending_fp), .dup(dup_fp)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] r);
    req = r;
    tick();
    req = 8'h00;
  endtask

  task automatic expect_both(input int rr_idx, input int fp_idx);
    q_rr.push_back(rr_idx);
    q_fp.push_back(fp_idx);
  endtask

  // Monitor: every accepted transfer is popped from the matching queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && valid_rr && ready) begin
        if (q_rr.size() == 0) check("rr_unexpected_S", int'(s_rr), -1);
        else check("rr_S", int'(s_rr), q_rr.pop_front());
      end
      if (reset_n && valid_fp && ready) begin
        if (q_fp.size() == 0) check("fp_unexpected_S", int'(s_fp), -1);
        else check("fp_S", int'(s_fp), q_fp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with all requests asserted
    req = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    check("rst_S", int'(s_rr), 0);
    check("rst_valid", int'(valid_rr), 0);
    check("rst_pending", int'(pending_rr), 0);
    check("rst_dup", int'(dup_rr), 0);
    check("rst_fp_pending", int'(pending_fp), 0);
    tick();
    reset_n = 1'b1;
    req = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("post_rst_valid", int'(valid_rr), 0);
    check("post_rst_pending", int'(pending_rr), 0);
    check("post_rst_S", int'(s_rr), 0);

    // Single request: pending at N+1, valid at N+2, gone at N+3
    ready = 1'b1;
    expect_both(4, 4);
    pulse(8'h10);
    @(negedge clk);
    check("single_pending", int'(pending_rr), 8'h10);
    check("single_valid_early", int'(valid_rr), 0);
    tick();
    @(negedge clk);
    check("single_valid", int'(valid_rr), 1);
    check("single_S", int'(s_rr), 4);
    check("single_pending_clr", int'(pending_rr), 0);
    tick();
    @(negedge clk);
    check("single_valid_drop", int'(valid_rr), 0);

    // Round-robin wrap: serve 5, then {0,5,7} -> 7,0,5 (fixed: 0,5,7)
    expect_both(5, 5);
    pulse(8'h20);
    repeat (3) tick();
    expect_both(7, 0);
    expect_both(0, 5);
    expect_both(5, 7);
    pulse(8'hA1);
    @(negedge clk);
    check("wrap_pending", int'(pending_rr), 8'hA1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("wrap_valid_cont", int'(valid_rr), 1);
      check("wrap_fp_valid_cont", int'(valid_fp), 1);
    end
    tick();
    @(negedge clk);
    check("wrap_valid_end", int'(valid_rr), 0);

    // Backpressure: S held while ready is low
    ready = 1'b0;
    expect_both(1, 1);
    expect_both(2, 2);
    pulse(8'h06);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_hold_S", int'(s_rr), 1);
      check("bp_hold_valid", int'(valid_rr), 1);
    end
    tick();
    ready = 1'b1;
    @(negedge clk);
    check("bp_first_S", int'(s_rr), 1);
    tick();
    @(negedge clk);
    check("bp_second_S", int'(s_rr), 2);
    tick();
    @(negedge clk);
    check("bp_valid_end", int'(valid_rr), 0);

    // Duplicate: second strobe for an already pending index
    ready = 1'b0;
    expect_both(0, 0);
    expect_both(3, 3);
    pulse(8'h01);
    tick();
    req = 8'h08;
    tick();
    tick();
    req = 8'h00;
    @(negedge clk);
    check("dup_pulse", int'(dup_rr), 1);
    check("dup_fp_pulse", int'(dup_fp), 1);
    check("dup_pending", int'(pending_rr), 8'h08);
    tick();
    @(negedge clk);
    check("dup_one_cycle", int'(dup_rr), 0);
    tick();
    ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("dup_valid_end", int'(valid_rr), 0);

    // Re-request of the index currently offered: served again, no dup
    ready = 1'b0;
    expect_both(3, 3);
    expect_both(3, 3);
    pulse(8'h08);
    tick();
    pulse(8'h08);
    @(negedge clk);
    check("coll_dup", int'(dup_rr), 0);
    check("coll_pending", int'(pending_rr), 8'h08);
    check("coll_S", int'(s_rr), 3);
    tick();
    ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("coll_valid_end", int'(valid_rr), 0);

    // Asynchronous reset mid-offer
    ready = 1'b0;
    pulse(8'hF0);
    tick();
    @(negedge clk);
    check("mid_S", int'(s_rr), 4);
    check("mid_valid", int'(valid_rr), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid_drop", int'(valid_rr), 0);
    check("async_fp_valid_drop", int'(valid_fp), 0);
    tick();
    @(negedge clk);
    check("async_pending", int'(pending_rr), 0);
    tick();
    reset_n = 1'b1;
    ready = 1'b1;
    expect_both(0, 0);
    expect_both(7, 7);
    pulse(8'h81);
    tick();
    @(negedge clk);
    check("ptr_reset_S", int'(s_rr), 0);
    repeat (4) tick();
    @(negedge clk);
    check("final_valid", int'(valid_rr), 0);
    check("rr_queue_drained", q_rr.size(), 0);
    check("fp_queue_drained", q_fp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
